mw_stage: RTL and testbench

- Memory stage of the 5-stage pipeline. Sits between the execute/memory pipeline register and the writeback stage.
- Consumes the latched ALU result, store operand, instruction word and overflow flag.
- Runs the data-memory load/store handshake, which may take several cycles, and stalls the front of the pipe while memory is busy.
- Registers the result into the memory/writeback pipeline register, inserting a bubble on every stall cycle.

---
 rtl/mw_stage_pkg.sv | 30 +++
 rtl/mw_latch.sv | 34 +++
 rtl/mw_stage.sv | 114 +++++++++++
 tb/tb_mw_stage.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/mw_stage_pkg.sv
// Shared processor definitions: opcodes, NOP encoding and the memory-stage
// handshake state encoding.
package mw_stage_pkg;

  localparam logic [4:0] OP_ALU  = 5'b00000;
  localparam logic [4:0] OP_J    = 5'b00001;
  localparam logic [4:0] OP_BNE  = 5'b00010;
  localparam logic [4:0] OP_JAL  = 5'b00011;
  localparam logic [4:0] OP_JR   = 5'b00100;
  localparam logic [4:0] OP_ADDI = 5'b00101;
  localparam logic [4:0] OP_BLT  = 5'b00110;
  localparam logic [4:0] OP_SW   = 5'b00111;
  localparam logic [4:0] OP_LW   = 5'b01000;

  localparam logic [31:0] NOP = 32'h0000_0000;

  localparam int TIMEOUT_DEF = 16;
  localparam int CNT_W_DEF   = 5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    ERR  = 2'd2
  } state_t;

  function automatic logic [4:0] opcode(input logic [31:0] ins);
    return ins[31:27];
  endfunction

endpackage

// File: rtl/mw_latch.sv
// Memory/writeback pipeline register with load enable and bubble insertion.
// Bubble has priority over load so a stalled cycle always writes a NOP.
module mw_latch
  import mw_stage_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        load,
  input  logic        bubble,
  input  logic [31:0] o,
  input  logic [31:0] d,
  input  logic [31:0] ins,
  input  logic        ovf,
  output logic [31:0] mw_o,
  output logic [31:0] mw_d,
  output logic [31:0] mw_ins,
  output logic        mw_ovf
);

  always_ff @(posedge clk) begin
    if (reset || bubble) begin
      mw_o   <= 32'h0;
      mw_d   <= 32'h0;
      mw_ins <= NOP;
      mw_ovf <= 1'b0;
    end else if (load) begin
      mw_o   <= o;
      mw_d   <= d;
      mw_ins <= ins;
      mw_ovf <= ovf;
    end
  end

endmodule

// File: rtl/mw_stage.sv
// Memory stage: decodes lw/sw, runs the data-memory handshake with a timeout,
// stalls the front of the pipe while memory is busy and feeds the MW register.
module mw_stage
  import mw_stage_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEF,
  parameter int CNT_W   = CNT_W_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] xm_o,
  input  logic [31:0] xm_b,
  input  logic [31:0] xm_ins,
  input  logic        xm_ovf,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  input  logic        dmem_ready,
  input  logic [31:0] dmem_rdata,
  output logic        stall,
  output logic        mem_err,
  output logic [31:0] mw_o,
  output logic [31:0] mw_d,
  output logic [31:0] mw_ins,
  output logic        mw_ovf,
  output logic [1:0]  fsm_state
);

  // Handshake: dmem_req is held with address/data/we stable (upstream is
  // frozen by stall) until the cycle dmem_ready=1; that cycle completes it.

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             mem_op, is_sw, is_lw, timeout_hit;
  logic [31:0]      load_data;

  assign is_sw  = (opcode(xm_ins) == OP_SW);
  assign is_lw  = (opcode(xm_ins) == OP_LW);
  assign mem_op = is_sw | is_lw;

  assign dmem_req   = mem_op & (state_q != ERR);
  assign dmem_we    = dmem_req & is_sw;
  assign dmem_addr  = xm_o;
  assign dmem_wdata = xm_b;

  assign stall     = dmem_req & ~dmem_ready & ~timeout_hit;
  assign load_data = (is_lw && dmem_ready && state_q != ERR) ? dmem_rdata : 32'h0;
  assign fsm_state = state_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      mem_err <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (timeout_hit) mem_err <= 1'b1;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    timeout_hit = 1'b0;
    case (state_q)
      IDLE: begin
        if (dmem_req && !dmem_ready) begin
          state_d = WAIT;
          cnt_d   = CNT_W'(1);
        end
      end
      WAIT: begin
        if (dmem_ready) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q == CNT_MAX) begin
          timeout_hit = 1'b1;
          state_d     = ERR;
          cnt_d       = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ERR: begin
        state_d = ERR;
        cnt_d   = '0;
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  mw_latch u_mw_latch (
    .clk    (clk),
    .reset  (reset),
    .load   (1'b1),
    .bubble (stall),
    .o      (xm_o),
    .d      (load_data),
    .ins    (xm_ins),
    .ovf    (xm_ovf),
    .mw_o   (mw_o),
    .mw_d   (mw_d),
    .mw_ins (mw_ins),
    .mw_ovf (mw_ovf)
  );

endmodule

// File: tb/tb_mw_stage.sv
// Directed bench for mw_stage: ALU pass-through, single- and multi-cycle
// accesses, timeout into ERR, reset mid-handshake and back-to-back accesses.
module tb_mw_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] xm_o, xm_b, xm_ins;
  logic        xm_ovf;
  logic        dmem_req, dmem_we;
  logic [31:0] dmem_addr, dmem_wdata;
  logic        dmem_ready;
  logic [31:0] dmem_rdata;
  logic        stall, mem_err;
  logic [31:0] mw_o, mw_d, mw_ins;
  logic        mw_ovf;
  logic [1:0]  fsm_state;

  int vectors = 0;
  int miscompares = 0;

  localparam logic [31:0] INS_ALU = 32'h0022_1000;
  localparam logic [31:0] INS_LW  = 32'h4100_0010;
  localparam logic [31:0] INS_LW2 = 32'h4120_0040;
  localparam logic [31:0] INS_SW  = 32'h3840_0004;

  mw_stage dut (
    .clk        (clk),
    .reset      (reset),
    .xm_o       (xm_o),
    .xm_b       (xm_b),
    .xm_ins     (xm_ins),
    .xm_ovf     (xm_ovf),
    .dmem_req   (dmem_req),
    .dmem_we    (dmem_we),
    .dmem_addr  (dmem_addr),
    .dmem_wdata (dmem_wdata),
    .dmem_ready (dmem_ready),
    .dmem_rdata (dmem_rdata),
    .stall      (stall),
    .mem_err    (mem_err),
    .mw_o       (mw_o),
    .mw_d       (mw_d),
    .mw_ins     (mw_ins),
    .mw_ovf     (mw_ovf),
    .fsm_state  (fsm_state)
  );

  always #5 clk = ~clk;

  // Inputs change 1ns after a rising edge; outputs are sampled 2ns later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    reset = 1'b1;
    xm_o = 32'h0; xm_b = 32'h0; xm_ins = 32'h0; xm_ovf = 1'b0;
    dmem_ready = 1'b0; dmem_rdata = 32'h0;
    tick(); tick();
    settle();
    chk("rst_mw_o", mw_o, 32'h0);
    chk("rst_mw_ins", mw_ins, 32'h0);
    chk("rst_mem_err", mem_err, 0);
    chk("rst_state", fsm_state, 0);
    reset = 1'b0;

    // 1: ALU op passes through in one cycle
    xm_ins = INS_ALU; xm_o = 32'd7; xm_ovf = 1'b1;
    settle();
    chk("alu_req", dmem_req, 0);
    chk("alu_stall", stall, 0);
    tick();
    chk("alu_mw_o", mw_o, 32'd7);
    chk("alu_mw_ins", mw_ins, INS_ALU);
    chk("alu_mw_ovf", mw_ovf, 1);
    chk("alu_mw_d", mw_d, 32'h0);

    // 2: single-cycle load
    xm_ins = INS_LW; xm_o = 32'h10; xm_ovf = 1'b0;
    dmem_ready = 1'b1; dmem_rdata = 32'hDEAD_BEEF;
    settle();
    chk("lw1_req", dmem_req, 1);
    chk("lw1_we", dmem_we, 0);
    chk("lw1_addr", dmem_addr, 32'h10);
    chk("lw1_stall", stall, 0);
    tick();
    chk("lw1_mw_d", mw_d, 32'hDEAD_BEEF);
    chk("lw1_mw_o", mw_o, 32'h10);
    chk("lw1_mw_ins", mw_ins, INS_LW);
    chk("lw1_state", fsm_state, 0);

    // 3: store with three wait cycles
    xm_ins = INS_SW; xm_o = 32'h20; xm_b = 32'd5;
    dmem_ready = 1'b0; dmem_rdata = 32'h1111_2222;
    for (int i = 0; i < 3; i++) begin
      settle();
      chk("sw_we_wait", dmem_we, 1);
      chk("sw_stall_wait", stall, 1);
      chk("sw_wdata", dmem_wdata, 32'd5);
      tick();
      chk("sw_bubble_ins", mw_ins, 32'h0);
      chk("sw_bubble_o", mw_o, 32'h0);
    end
    dmem_ready = 1'b1;
    settle();
    chk("sw_we_done", dmem_we, 1);
    chk("sw_stall_done", stall, 0);
    tick();
    chk("sw_mw_ins", mw_ins, INS_SW);
    chk("sw_mw_o", mw_o, 32'h20);
    chk("sw_mw_d", mw_d, 32'h0);
    chk("sw_state", fsm_state, 0);

    // 4: load that never completes -> timeout into ERR
    xm_ins = INS_LW2; xm_o = 32'h40; dmem_ready = 1'b0;
    for (int i = 0; i < 16; i++) begin
      settle();
      chk("to_stall", stall, 1);
      tick();
    end
    settle();
    chk("to_stall_drop", stall, 0);
    chk("to_err_late", mem_err, 0);
    tick();
    chk("to_mem_err", mem_err, 1);
    chk("to_state", fsm_state, 2);
    chk("to_mw_ins", mw_ins, INS_LW2);
    chk("to_mw_d", mw_d, 32'h0);
    xm_ins = INS_LW; xm_o = 32'h44; dmem_ready = 1'b1; dmem_rdata = 32'h0000_1234;
    settle();
    chk("err_req", dmem_req, 0);
    chk("err_stall", stall, 0);
    tick();
    chk("err_mw_d", mw_d, 32'h0);
    chk("err_mw_ins", mw_ins, INS_LW);
    chk("err_mw_o", mw_o, 32'h44);
    xm_ins = INS_SW; dmem_ready = 1'b0;
    settle();
    chk("err_sw_we", dmem_we, 0);

    // 5: reset leaves ERR, then reset in the 2nd WAIT cycle
    reset = 1'b1;
    tick();
    settle();
    chk("rst1_mem_err", mem_err, 0);
    chk("rst1_state", fsm_state, 0);
    chk("rst1_mw_ins", mw_ins, 32'h0);
    reset = 1'b0;
    xm_ins = INS_LW; xm_o = 32'h48; dmem_ready = 1'b0;
    settle();
    chk("rst2_stall_idle", stall, 1);
    tick();
    settle();
    chk("rst2_wait1", fsm_state, 1);
    tick();
    settle();
    chk("rst2_wait2", fsm_state, 1);
    reset = 1'b1;
    tick();
    settle();
    chk("rst2_state", fsm_state, 0);
    chk("rst2_mw_o", mw_o, 32'h0);
    chk("rst2_mw_d", mw_d, 32'h0);
    chk("rst2_mem_err", mem_err, 0);
    reset = 1'b0;
    xm_ins = INS_ALU; xm_o = 32'h3;
    settle();
    chk("rst2_stall", stall, 0);

    // 6: back-to-back lw then sw, one wait cycle each
    tick();
    xm_ins = INS_LW; xm_o = 32'h50; dmem_ready = 1'b0;
    settle();
    chk("b2b_lw_stall", stall, 1);
    tick();
    chk("b2b_lw_bubble", mw_ins, 32'h0);
    dmem_ready = 1'b1; dmem_rdata = 32'hCAFE_F00D;
    settle();
    chk("b2b_lw_state", fsm_state, 1);
    chk("b2b_lw_nostall", stall, 0);
    tick();
    chk("b2b_lw_mw_d", mw_d, 32'hCAFE_F00D);
    chk("b2b_lw_mw_ins", mw_ins, INS_LW);
    xm_ins = INS_SW; xm_o = 32'h54; xm_b = 32'h77; dmem_ready = 1'b0;
    settle();
    chk("b2b_sw_idle", fsm_state, 0);
    chk("b2b_sw_stall", stall, 1);
    chk("b2b_sw_we", dmem_we, 1);
    tick();
    dmem_ready = 1'b1;
    settle();
    chk("b2b_sw_state", fsm_state, 1);
    chk("b2b_sw_we_done", dmem_we, 1);
    chk("b2b_sw_wdata", dmem_wdata, 32'h77);
    chk("b2b_sw_nostall", stall, 0);
    tick();
    chk("b2b_sw_mw_ins", mw_ins, INS_SW);
    chk("b2b_sw_mw_o", mw_o, 32'h54);

    // dmem_ready without a request is ignored
    xm_ins = INS_ALU; xm_o = 32'h9; dmem_ready = 1'b1; dmem_rdata = 32'hFFFF_FFFF;
    settle();
    chk("ign_req", dmem_req, 0);
    tick();
    chk("ign_mw_d", mw_d, 32'h0);
    chk("ign_state", fsm_state, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
